// File: rtl/rubiks_move_pkg.sv
// Shared definitions for the face-move receiver: face codes, executor states
// and the 12-line one-hot move classifier.
package rubiks_move_pkg;

  localparam logic [2:0] FACE_RIGHT  = 3'd0;
  localparam logic [2:0] FACE_LEFT   = 3'd1;
  localparam logic [2:0] FACE_FRONT  = 3'd2;
  localparam logic [2:0] FACE_BACK   = 3'd3;
  localparam logic [2:0] FACE_TOP    = 3'd4;
  localparam logic [2:0] FACE_BOTTOM = 3'd5;

  localparam int unsigned ACW_BIT   = 3;
  localparam logic [3:0]  MOVE_IDLE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIR    = 3'd1,
    ST_STEP_H = 3'd2,
    ST_STEP_L = 3'd3,
    ST_SETTLE = 3'd4
  } exec_state_e;

  typedef struct packed {
    logic       valid;
    logic       multi;
    logic [3:0] code;
  } move_class_t;

  // Line i maps to face i/2 with the anticlockwise flag in i%2.
  function automatic move_class_t onehot12_to_code(input logic [11:0] lines);
    move_class_t r;
    int unsigned ones;
    r.valid = 1'b0;
    r.multi = 1'b0;
    r.code  = MOVE_IDLE;
    ones    = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (lines[i]) begin
        ones++;
        r.code = {i[0], i[3:1]};
      end
    end
    r.valid = (ones == 1);
    r.multi = (ones > 1);
    return r;
  endfunction

endpackage

// File: rtl/rubiks_move_receiver_fifo.sv
// Synchronous 4-bit move queue with flush; push while full is accepted only
// when a pop frees the slot in the same cycle.
module move_fifo #(
  parameter int unsigned DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [3:0]                   wr_data,
  output logic [3:0]                   rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/rubiks_move_receiver.sv
// Receives one-hot face moves from the sequencer cable, queues them and plays
// each one out as a dir setup, a step pulse train and a settle dwell.
module rubiks_move_receiver
  import rubiks_move_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 32,
  parameter int unsigned STEPS_PER_QTR = 50,
  parameter int unsigned PULSE_HI      = 500,
  parameter int unsigned PULSE_LO      = 500,
  parameter int unsigned DIR_SETUP     = 100,
  parameter int unsigned SETTLE_CYCLES = 25000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_tick,
  input  logic [11:0] move_lines,
  input  logic        enable,
  input  logic        clear,
  output logic [5:0]  step,
  output logic [5:0]  dir,
  output logic        busy,
  output logic [3:0]  cur_code,
  output logic [5:0]  fifo_count,
  output logic        err_multi,
  output logic        err_ovf,
  output logic [15:0] moves_done
);

  localparam int unsigned T_A  = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
  localparam int unsigned T_B  = (SETTLE_CYCLES > DIR_SETUP) ? SETTLE_CYCLES : DIR_SETUP;
  localparam int unsigned TMAX = (T_A > T_B) ? T_A : T_B;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned SW   = $clog2(STEPS_PER_QTR + 1);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

  logic        tick_meta_q, tick_meta_d, tick_sync_q, tick_sync_d, tick_prev_q, tick_prev_d;
  logic [11:0] lines_meta_q, lines_meta_d, lines_sync_q, lines_sync_d;
  logic        smp_vld_q, smp_vld_d;
  logic [11:0] smp_lines_q, smp_lines_d;
  logic        push_q, push_d;
  logic [3:0]  push_code_q, push_code_d;
  logic        err_multi_q, err_multi_d, err_ovf_q, err_ovf_d;
  move_class_t cls;

  exec_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [3:0]    cur_code_q, cur_code_d;
  logic [5:0]    dir_q, dir_d, step_q, step_d;
  logic [15:0]   moves_done_q, moves_done_d;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [3:0]    fifo_rd_data;
  logic [CW-1:0] fifo_cnt;

  move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_q),
    .pop     (fifo_pop),
    .clear   (clear),
    .wr_data (push_code_q),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // Sample on the synchronised falling tick edge, classify a cycle later,
  // push the cycle after that.
  always_comb begin
    tick_meta_d  = move_tick;
    tick_sync_d  = tick_meta_q;
    tick_prev_d  = tick_sync_q;
    lines_meta_d = move_lines;
    lines_sync_d = lines_meta_q;
    smp_vld_d    = tick_prev_q & ~tick_sync_q;
    smp_lines_d  = smp_vld_d ? lines_sync_q : smp_lines_q;
    cls          = onehot12_to_code(smp_lines_q);
    push_d       = smp_vld_q & cls.valid;
    push_code_d  = cls.code;
    err_multi_d  = clear ? 1'b0 : (err_multi_q | (smp_vld_q & cls.multi));
    err_ovf_d    = clear ? 1'b0 : (err_ovf_q | (push_q & fifo_full & ~fifo_pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_meta_q  <= 1'b0;
      tick_sync_q  <= 1'b0;
      tick_prev_q  <= 1'b0;
      lines_meta_q <= '0;
      lines_sync_q <= '0;
      smp_vld_q    <= 1'b0;
      smp_lines_q  <= '0;
      push_q       <= 1'b0;
      push_code_q  <= '0;
      err_multi_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      tick_meta_q  <= tick_meta_d;
      tick_sync_q  <= tick_sync_d;
      tick_prev_q  <= tick_prev_d;
      lines_meta_q <= lines_meta_d;
      lines_sync_q <= lines_sync_d;
      smp_vld_q    <= smp_vld_d;
      smp_lines_q  <= smp_lines_d;
      push_q       <= push_d;
      push_code_q  <= push_code_d;
      err_multi_q  <= err_multi_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 1'b1;
    steps_d      = steps_q;
    cur_code_d   = cur_code_q;
    dir_d        = dir_q;
    moves_done_d = moves_done_q;
    fifo_pop     = 1'b0;
    step_d       = '0;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (enable && !fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_code_d = fifo_rd_data;
          steps_d    = '0;
          for (int unsigned f = 0; f < 6; f++) begin
            if (fifo_rd_data[2:0] == 3'(f)) dir_d[f] = fifo_rd_data[ACW_BIT];
          end
          state_d = ST_DIR;
        end
      end
      ST_DIR: begin
        if (timer_q == TW'(DIR_SETUP - 1)) begin
          timer_d = '0;
          state_d = ST_STEP_H;
        end
      end
      ST_STEP_H: begin
        if (timer_q == TW'(PULSE_HI - 1)) begin
          timer_d = '0;
          steps_d = steps_q + 1'b1;
          state_d = ST_STEP_L;
        end
      end
      ST_STEP_L: begin
        if (timer_q == TW'(PULSE_LO - 1)) begin
          timer_d = '0;
          state_d = (steps_q < SW'(STEPS_PER_QTR)) ? ST_STEP_H : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
          timer_d      = '0;
          moves_done_d = moves_done_q + 1'b1;
          cur_code_d   = MOVE_IDLE;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    // Step is registered from the next state so the pulse is glitch-free.
    for (int unsigned f = 0; f < 6; f++) begin
      if (state_d == ST_STEP_H && cur_code_q[2:0] == 3'(f)) step_d[f] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      steps_q      <= '0;
      cur_code_q   <= MOVE_IDLE;
      dir_q        <= '0;
      step_q       <= '0;
      moves_done_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      steps_q      <= steps_d;
      cur_code_q   <= cur_code_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      moves_done_q <= moves_done_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign busy       = (state_q != ST_IDLE);
  assign cur_code   = cur_code_q;
  assign fifo_count = 6'(fifo_cnt);
  assign err_multi  = err_multi_q;
  assign err_ovf    = err_ovf_q;
  assign moves_done = moves_done_q;

endmodule

// File: tb/tb_rubiks_move_receiver.sv
// Scenario bench for rubiks_move_receiver: drives sequencer ticks and checks
// executed moves, queue depth and sticky flags against a queue-based model.
module tb_rubiks_move_receiver;

  localparam int QTR = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        move_tick = 1'b0;
  logic [11:0] move_lines = '0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [5:0]  step, dir, fifo_count;
  logic        busy, err_multi, err_ovf;
  logic [3:0]  cur_code;
  logic [15:0] moves_done;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] code;
    int         pulses;
    logic       dirv;
  } mv_t;

  mv_t        obs_q[$];
  logic [3:0] exp_q[$];
  int         model_done = 0;
  int         pending = 0;
  bit         model_multi = 1'b0;
  bit         model_ovf = 1'b0;
  int         stray = 0;

  bit         in_move = 1'b0;
  mv_t        rec;
  logic [5:0] prev_step = '0;
  logic [2:0] mface;

  rubiks_move_receiver #(
    .FIFO_DEPTH    (32),
    .STEPS_PER_QTR (QTR),
    .PULSE_HI      (2),
    .PULSE_LO      (2),
    .DIR_SETUP     (1),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .move_tick  (move_tick),
    .move_lines (move_lines),
    .enable     (enable),
    .clear      (clear),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .cur_code   (cur_code),
    .fifo_count (fifo_count),
    .err_multi  (err_multi),
    .err_ovf    (err_ovf),
    .moves_done (moves_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Move recorder: one record per busy period, pulses counted on the face of the code shown.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_move   = 1'b0;
      prev_step = '0;
    end else begin
      if (in_move && !busy) begin
        obs_q.push_back(rec);
        in_move = 1'b0;
      end else if (!in_move && busy) begin
        in_move    = 1'b1;
        rec.code   = cur_code;
        rec.pulses = 0;
        rec.dirv   = 1'bx;
      end
      mface = rec.code[2:0];
      for (int f = 0; f < 6; f++) begin
        if (step[f] && !prev_step[f]) begin
          if (in_move && f == int'(mface)) begin
            rec.pulses++;
            if (rec.pulses == 1) rec.dirv = dir[f];
          end else begin
            stray++;
          end
        end
      end
      if (in_move && cur_code !== rec.code) stray++;
      prev_step = step;
    end
  end

  function automatic logic [11:0] rand_onehot();
    logic [11:0] v;
    v = '0;
    v[$urandom_range(0, 11)] = 1'b1;
    return v;
  endfunction

  task automatic send_tick(input logic [11:0] l, input bit keep);
    int ones;
    int idx;
    ones = $countones(l);
    idx  = 0;
    for (int i = 0; i < 12; i++) if (l[i]) idx = i;
    move_lines = l;
    repeat (2) @(negedge clk);
    move_tick = 1'b1;
    repeat (4) @(negedge clk);
    move_tick = 1'b0;
    repeat (6) @(negedge clk);
    if (!keep) move_lines = '0;
    repeat (2) @(negedge clk);
    if (ones > 1) begin
      model_multi = 1'b1;
    end else if (ones == 1) begin
      if (!enable && pending >= 32) begin
        model_ovf = 1'b1;
      end else begin
        exp_q.push_back(4'((idx % 2) * 8 + idx / 2));
        if (!enable) pending++;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clk);
      if (!busy && fifo_count == 6'd0) quiet++;
      else quiet = 0;
      if (quiet >= 4) ok = 1'b1;
    end
    pending = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({step, dir, busy, cur_code} !== {6'h00, 6'h00, 1'b0, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_outputs: step=%h dir=%h busy=%b cur_code=%h, required 00 00 0 f", step, dir, busy, cur_code);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({fifo_count, err_multi, err_ovf, moves_done, cur_code} !== {6'd0, 1'b0, 1'b0, 16'd0, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d multi=%b ovf=%b done=%0d code=%h, required 0 0 0 0 f",
               fifo_count, err_multi, err_ovf, moves_done, cur_code);
    end
  endtask

  task automatic test_single();
    bit ok;
    enable = 1'b1;
    send_tick(12'h010, 1'b0);
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: busy=%b count=%0d, required idle", busy, fifo_count); end
    n_vec++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: %0d moves, required 1", obs_q.size());
    end else if ({obs_q[0].code, obs_q[0].dirv, obs_q[0].pulses} !== {4'h2, 1'b0, QTR}) begin
      n_fail++;
      $display("FAIL single_move: code=%h dir=%b pulses=%0d, required 2 0 %0d", obs_q[0].code, obs_q[0].dirv, obs_q[0].pulses, QTR);
    end
    model_done += exp_q.size();
    obs_q.delete(); exp_q.delete();
    n_vec++;
    if (moves_done !== 16'(model_done)) begin
      n_fail++; $display("FAIL single_done: moves_done=%0d, required %0d", moves_done, model_done);
    end
  endtask

  task automatic test_repeat();
    bit ok;
    send_tick(12'h080, 1'b1);
    send_tick(12'h080, 1'b0);
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL repeat_timeout: busy=%b count=%0d, required idle", busy, fifo_count); end
    n_vec++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL repeat_count: %0d moves, required 2", obs_q.size());
    end else begin
      foreach (obs_q[i]) begin
        n_vec++;
        if ({obs_q[i].code, obs_q[i].dirv, obs_q[i].pulses} !== {4'hB, 1'b1, QTR}) begin
          n_fail++;
          $display("FAIL repeat_move[%0d]: code=%h dir=%b pulses=%0d, required b 1 %0d", i, obs_q[i].code, obs_q[i].dirv, obs_q[i].pulses, QTR);
        end
      end
    end
    model_done += exp_q.size();
    obs_q.delete(); exp_q.delete();
    n_vec++;
    if (moves_done !== 16'(model_done)) begin
      n_fail++; $display("FAIL repeat_done: moves_done=%0d, required %0d", moves_done, model_done);
    end
  endtask

  task automatic test_multi();
    bit ok;
    n_vec++;
    if (err_multi !== 1'b0) begin n_fail++; $display("FAIL multi_pre: err_multi=%b, required 0", err_multi); end
    send_tick(12'h003, 1'b0);
    n_vec++;
    if ({err_multi, fifo_count, busy} !== {1'b1, 6'd0, 1'b0}) begin
      n_fail++; $display("FAIL multi_flag: err_multi=%b count=%0d busy=%b, required 1 0 0", err_multi, fifo_count, busy);
    end
    send_tick(12'h001, 1'b0);
    wait_idle(ok);
    n_vec++;
    if (!ok || obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL multi_follow_count: %0d moves ok=%b, required 1 move", obs_q.size(), ok);
    end else if ({obs_q[0].code, obs_q[0].dirv, obs_q[0].pulses} !== {4'h0, 1'b0, QTR}) begin
      n_fail++;
      $display("FAIL multi_follow_move: code=%h dir=%b pulses=%0d, required 0 0 %0d", obs_q[0].code, obs_q[0].dirv, obs_q[0].pulses, QTR);
    end
    model_done += exp_q.size();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    logic [11:0] l;
    int a, b;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_multi = 1'b0;
    model_ovf = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({err_multi, err_ovf} !== 2'b00) begin
      n_fail++; $display("FAIL random_clear: err_multi=%b err_ovf=%b, required 0 0", err_multi, err_ovf);
    end
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 3))
        0: l = '0;
        3: begin
          a = $urandom_range(0, 11);
          b = (a + $urandom_range(1, 11)) % 12;
          l = '0; l[a] = 1'b1; l[b] = 1'b1;
          l = l | 12'($urandom);
        end
        default: l = rand_onehot();
      endcase
      send_tick(l, 1'b0);
    end
    wait_idle(ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_count: %0d moves ok=%b, required %0d", obs_q.size(), ok, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_vec++;
        if ({obs_q[i].code, obs_q[i].dirv, obs_q[i].pulses} !== {exp_q[i], exp_q[i][3], QTR}) begin
          n_fail++;
          $display("FAIL random_move[%0d]: code=%h dir=%b pulses=%0d, required %h %b %0d",
                   i, obs_q[i].code, obs_q[i].dirv, obs_q[i].pulses, exp_q[i], exp_q[i][3], QTR);
        end
      end
    end
    model_done += exp_q.size();
    obs_q.delete(); exp_q.delete();
    n_vec++;
    if ({err_multi, err_ovf, moves_done} !== {model_multi, 1'b0, 16'(model_done)}) begin
      n_fail++;
      $display("FAIL random_status: err_multi=%b err_ovf=%b done=%0d, required %b 0 %0d", err_multi, err_ovf, moves_done, model_multi, model_done);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    enable = 1'b0;
    pending = 0;
    for (int n = 0; n < 32; n++) send_tick(rand_onehot(), 1'b0);
    n_vec++;
    if ({fifo_count, err_ovf, busy} !== {6'd32, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL ovf_full: count=%0d err_ovf=%b busy=%b, required 32 0 0", fifo_count, err_ovf, busy);
    end
    send_tick(rand_onehot(), 1'b0);
    n_vec++;
    if ({fifo_count, err_ovf} !== {6'd32, model_ovf}) begin
      n_fail++; $display("FAIL ovf_drop: count=%0d err_ovf=%b, required 32 %b", fifo_count, err_ovf, model_ovf);
    end
    enable = 1'b1;
    wait_idle(ok);
    n_vec++;
    if (!ok || obs_q.size() != 32 || exp_q.size() != 32) begin
      n_fail++; $display("FAIL ovf_drain_count: %0d moves ok=%b, required 32", obs_q.size(), ok);
    end else begin
      foreach (exp_q[i]) begin
        n_vec++;
        if ({obs_q[i].code, obs_q[i].dirv, obs_q[i].pulses} !== {exp_q[i], exp_q[i][3], QTR}) begin
          n_fail++;
          $display("FAIL ovf_order[%0d]: code=%h dir=%b pulses=%0d, required %h %b %0d",
                   i, obs_q[i].code, obs_q[i].dirv, obs_q[i].pulses, exp_q[i], exp_q[i][3], QTR);
        end
      end
    end
    model_done += exp_q.size();
    obs_q.delete(); exp_q.delete();
    n_vec++;
    if (moves_done !== 16'(model_done)) begin
      n_fail++; $display("FAIL ovf_done: moves_done=%0d, required %0d", moves_done, model_done);
    end
  endtask

  task automatic test_control();
    bit seen;
    enable = 1'b0;
    pending = 0;
    for (int n = 0; n < 3; n++) send_tick(rand_onehot(), 1'b0);
    n_vec++;
    if (fifo_count !== 6'd3) begin n_fail++; $display("FAIL ctl_queued: count=%0d, required 3", fifo_count); end
    enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (step != 6'd0) seen = 1'b1;
    end
    enable = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    repeat (6) @(negedge clk);
    n_vec++;
    if ({seen, busy, fifo_count} !== {1'b1, 1'b0, 6'd2}) begin
      n_fail++; $display("FAIL ctl_hold: idle_seen=%b busy=%b count=%0d, required 1 0 2", seen, busy, fifo_count);
    end
    n_vec++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL ctl_one_move: %0d moves, required 1", obs_q.size());
    end else if ({obs_q[0].code, obs_q[0].dirv, obs_q[0].pulses} !== {exp_q[0], exp_q[0][3], QTR}) begin
      n_fail++;
      $display("FAIL ctl_move: code=%h dir=%b pulses=%0d, required %h %b %0d",
               obs_q[0].code, obs_q[0].dirv, obs_q[0].pulses, exp_q[0], exp_q[0][3], QTR);
    end
    model_done += 1;
    obs_q.delete(); exp_q.delete();
    n_vec++;
    if ({err_ovf, moves_done} !== {1'b1, 16'(model_done)}) begin
      n_fail++; $display("FAIL ctl_pre_clear: err_ovf=%b done=%0d, required 1 %0d", err_ovf, moves_done, model_done);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    model_multi = 1'b0;
    model_ovf = 1'b0;
    n_vec++;
    if ({fifo_count, err_multi, err_ovf, busy} !== {6'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ctl_clear: count=%0d err_multi=%b err_ovf=%b busy=%b, required 0 0 0 0", fifo_count, err_multi, err_ovf, busy);
    end
  endtask

  task automatic test_reset_mid_move();
    bit seen;
    enable = 1'b0;
    pending = 0;
    send_tick(rand_onehot(), 1'b0);
    send_tick(rand_onehot(), 1'b0);
    enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (step != 6'd0) seen = 1'b1;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({seen, step, cur_code, busy, fifo_count} !== {1'b1, 6'd0, 4'hF, 1'b0, 6'd0}) begin
      n_fail++;
      $display("FAIL rst_async: step_seen=%b step=%h code=%h busy=%b count=%0d, required 1 00 f 0 0", seen, step, cur_code, busy, fifo_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete();
    model_done = 0;
    repeat (20) @(negedge clk);
    n_vec++;
    if ({busy, fifo_count, moves_done, err_multi, err_ovf} !== {1'b0, 6'd0, 16'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_after: busy=%b count=%0d done=%0d multi=%b ovf=%b, required 0 0 0 0 0", busy, fifo_count, moves_done, err_multi, err_ovf);
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rst_no_move: %0d moves, required 0", obs_q.size()); end
  endtask

  task automatic test_step_isolation();
    n_vec++;
    if (stray != 0) begin
      n_fail++; $display("FAIL step_isolation: %0d stray step edges or code changes, required 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_multi();
    test_random();
    test_overflow();
    test_control();
    test_reset_mid_move();
    test_step_isolation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
